// File: rtl/kamus_csr_counters.sv
// -----------------------------------------------------------------------------
// kamus_csr_counters
//
// Machine counter/timer CSR unit for the kamus core. Holds mcycle, mtime,
// minstret, NUM_HPM event counters, mtimecmp and mcountinhibit. It serves one
// CSR read/modify/write per cycle from the execute stage and raises the
// machine timer interrupt.
//
// Parameters:
//   COUNTER_WIDTH  bits per counter and mtimecmp (33..64); upper bits read 0
//   NUM_HPM        number of event counters (0..29)
//   TIME_DIV       clk_i cycles per mtime tick (1..1024)
//
// Optional feature macro: KAMUS_USER_COUNTERS_EN
//   Defined     : read-only user aliases cycle/time/instret are mapped at
//                 0xC00-0xC02 (low) and 0xC80-0xC82 (high).
//   Not defined : those addresses are illegal.
//
// Ports:
//   clk_i          core clock
//   rst_i          synchronous active-high reset
//   csr_valid_i    CSR access this cycle
//   csr_addr_i     CSR address
//   csr_op_i       00 read, 01 write, 10 set, 11 clear
//   csr_wdata_i    write / mask operand
//   csr_rdata_o    pre-write value of the addressed CSR (combinational)
//   csr_illegal_o  unmapped address or write to a read-only alias
//   instret_i      one instruction retired this cycle
//   hpm_event_i    per-counter event pulse
//   timer_irq_o    registered mtime >= mtimecmp
//
// Access protocol: csr_valid_i qualifies a single-cycle access. There is no
// ready; the unit always accepts. Read data and csr_illegal_o are valid in the
// same cycle, and any write commits at the clock edge that ends the access.
// -----------------------------------------------------------------------------
module kamus_csr_counters #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_HPM       = 4,
  parameter int TIME_DIV      = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   csr_valid_i,
  input  logic [11:0]                            csr_addr_i,
  input  logic [1:0]                             csr_op_i,
  input  logic [31:0]                            csr_wdata_i,
  output logic [31:0]                            csr_rdata_o,
  output logic                                   csr_illegal_o,
  input  logic                                   instret_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  output logic                                   timer_irq_o
);

  localparam int CW   = COUNTER_WIDTH;
  localparam int HW   = COUNTER_WIDTH - 32;
  // Counter slots: 0 mcycle, 1 mtime, 2 minstret, 3+i hpm[i]. The same index
  // is the mcountinhibit bit and the low 5 bits of the 0xF00/0xF80 address.
  localparam int NCNT = 3 + NUM_HPM;
  localparam logic [5:0] NCNT_L     = 6'(NCNT);
  localparam logic [9:0] PRESC_LAST = 10'(TIME_DIV - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // State
  logic [CW-1:0]   cnt_q [NCNT];
  logic [CW-1:0]   cnt_d [NCNT];
  logic [CW-1:0]   mtimecmp_q, mtimecmp_d;
  logic [NCNT-1:0] inhibit_q, inhibit_d;
  logic [9:0]      presc_q, presc_d;
  logic            irq_q, irq_d;

  // Decode
  logic        sel_cnt, sel_cmp, sel_inh, sel_hi, sel_ro, sel_any;
  logic [4:0]  sel_idx;
  logic        is_wr_op, acc_bad, wr_en;
  logic [CW-1:0] cnt_sel;
  logic [31:0] old_val, new_val;
  logic        tick;
  logic [NCNT-1:0] inc_vec;

  always_comb begin
    sel_cnt = 1'b0;
    sel_cmp = 1'b0;
    sel_inh = 1'b0;
    sel_hi  = 1'b0;
    sel_ro  = 1'b0;
    sel_idx = csr_addr_i[4:0];
    // 0xF00-0xF1F and 0xF80-0xF9F; bit 7 picks the high half.
    if (csr_addr_i[11:5] == 7'h78 || csr_addr_i[11:5] == 7'h7C) begin
      sel_cnt = ({1'b0, csr_addr_i[4:0]} < NCNT_L);
      sel_hi  = csr_addr_i[7];
    end
`ifdef KAMUS_USER_COUNTERS_EN
    // 0xC00-0xC02 / 0xC80-0xC82 alias slots 0..2 read-only.
    else if (csr_addr_i[11:8] == 4'hC && csr_addr_i[6:2] == 5'd0 &&
             csr_addr_i[1:0] != 2'b11) begin
      sel_cnt = 1'b1;
      sel_ro  = 1'b1;
      sel_hi  = csr_addr_i[7];
      sel_idx = {3'b000, csr_addr_i[1:0]};
    end
`endif
    else if (csr_addr_i == 12'h7C1 || csr_addr_i == 12'h7C2) begin
      sel_cmp = 1'b1;
      sel_hi  = csr_addr_i[1];
    end else if (csr_addr_i == 12'h320) begin
      sel_inh = 1'b1;
    end
  end

  assign sel_any       = sel_cnt | sel_cmp | sel_inh;
  assign is_wr_op      = (csr_op_i != OP_READ);
  assign acc_bad       = !sel_any || (sel_ro && is_wr_op);
  assign csr_illegal_o = csr_valid_i && acc_bad;
  assign wr_en         = csr_valid_i && !acc_bad && is_wr_op;

  // Read mux: pre-write value of the addressed half, zero-extended.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (sel_idx == 5'(i)) cnt_sel = cnt_q[i];
    end
    old_val = '0;
    if (sel_cnt) begin
      old_val = sel_hi ? 32'(cnt_sel[CW-1:32]) : cnt_sel[31:0];
    end else if (sel_cmp) begin
      old_val = sel_hi ? 32'(mtimecmp_q[CW-1:32]) : mtimecmp_q[31:0];
    end else if (sel_inh) begin
      old_val = 32'(inhibit_q);
    end
  end

  assign csr_rdata_o = acc_bad ? 32'd0 : old_val;

  always_comb begin
    case (csr_op_i)
      OP_WRITE: new_val = csr_wdata_i;
      OP_SET:   new_val = old_val | csr_wdata_i;
      OP_CLEAR: new_val = old_val & ~csr_wdata_i;
      default:  new_val = old_val;
    endcase
  end

  // Next-state for counters, prescaler, mtimecmp, inhibit and irq.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = presc_q;
    // An inhibited mtime freezes its prescaler too.
    if (!inhibit_q[1]) presc_d = tick ? 10'd0 : presc_q + 10'd1;

    inc_vec    = '0;
    inc_vec[0] = 1'b1;
    inc_vec[1] = tick;
    inc_vec[2] = instret_i;
    for (int j = 0; j < NUM_HPM; j++) inc_vec[3+j] = hpm_event_i[j];

    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      // A write wins over the increment; the other half holds.
      if (wr_en && sel_cnt && sel_idx == 5'(i)) begin
        if (sel_hi) cnt_d[i] = {new_val[HW-1:0], cnt_q[i][31:0]};
        else        cnt_d[i] = {cnt_q[i][CW-1:32], new_val};
      end else if (inc_vec[i] && !inhibit_q[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_en && sel_cmp) begin
      if (sel_hi) mtimecmp_d = {new_val[HW-1:0], mtimecmp_q[31:0]};
      else        mtimecmp_d = {mtimecmp_q[CW-1:32], new_val};
    end

    inhibit_d = inhibit_q;
    if (wr_en && sel_inh) inhibit_d = new_val[NCNT-1:0];

    // Compare next-state values so the irq tracks the register it follows.
    irq_d = (cnt_d[1] >= mtimecmp_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      mtimecmp_q <= '1;
      inhibit_q  <= '0;
      presc_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mtimecmp_q <= mtimecmp_d;
      inhibit_q  <= inhibit_d;
      presc_q    <= presc_d;
      irq_q      <= irq_d;
    end
  end

  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_kamus_csr_counters.sv
module tb_kamus_csr_counters;

  localparam int CW   = 40;
  localparam int NHPM = 4;
  localparam int TDIV = 4;

`ifdef KAMUS_USER_COUNTERS_EN
  localparam logic USER_EN = 1'b1;
`else
  localparam logic USER_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1;
  logic            csr_valid_i = 1'b0;
  logic [11:0]     csr_addr_i = '0;
  logic [1:0]      csr_op_i = '0;
  logic [31:0]     csr_wdata_i = '0;
  logic [31:0]     csr_rdata_o;
  logic            csr_illegal_o;
  logic            instret_i = 1'b0;
  logic [NHPM-1:0] hpm_event_i = '0;
  logic            timer_irq_o;

  kamus_csr_counters #(
    .COUNTER_WIDTH(CW),
    .NUM_HPM(NHPM),
    .TIME_DIV(TDIV)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .csr_valid_i(csr_valid_i),
    .csr_addr_i(csr_addr_i),
    .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o),
    .instret_i(instret_i),
    .hpm_event_i(hpm_event_i),
    .timer_irq_o(timer_irq_o)
  );

  // ---------------- scoreboard ----------------
  // Entry: {check rdata, expected illegal, expected rdata}
  logic [33:0] exp_q[$];
  string       name_q[$];
  logic        chk_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: access with no expected entry");
      end else begin
        logic [33:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (csr_illegal_o !== e[32] || (e[33] && csr_rdata_o !== e[31:0]))
          $display("FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                   nm, csr_rdata_o, csr_illegal_o, e[31:0], e[32]);
        else
          n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic chk_rd,
                        input logic [31:0] exp_rd, input logic exp_ill,
                        input logic instr, input string nm);
    csr_valid_i = 1'b1;
    csr_addr_i  = a;
    csr_op_i    = op;
    csr_wdata_i = wd;
    instret_i   = instr;
    exp_q.push_back({chk_rd, exp_ill, exp_rd});
    name_q.push_back(nm);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk_en      = 1'b0;
    csr_valid_i = 1'b0;
    csr_op_i    = 2'b00;
    csr_wdata_i = $urandom();
    csr_addr_i  = 12'($urandom_range(0, 4095));
    instret_i   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp_rd, input string nm);
    access(a, 2'b00, 32'd0, 1'b1, exp_rd, 1'b0, 1'b0, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_old, input string nm);
    access(a, 2'b01, wd, 1'b1, exp_old, 1'b0, 1'b0, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_irq(input logic expv, input string nm);
    n_checks++;
    if (timer_irq_o !== expv)
      $display("FAIL %s: timer_irq_o=%b, expected %b", nm, timer_irq_o, expv);
    else
      n_pass++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ill;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] wd, input logic chk_rd,
                         input logic [31:0] exp_rd, input logic exp_ill,
                         input string nm);
    vec_t v;
    v.addr = a; v.op = op; v.wdata = wd; v.chk_rd = chk_rd;
    v.exp_rd = exp_rd; v.exp_ill = exp_ill; v.name = nm;
    tbl.push_back(v);
  endtask

  // Watchdog: the run is fixed-length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vectors whose results do not depend on free-running counters.
    add_vec(12'h7C1, 2'b00, 32'h0,        1'b1, 32'hFFFF_FFFF, 1'b0, "cmp_lo_rst");
    add_vec(12'h7C2, 2'b00, 32'h0,        1'b1, 32'h0000_00FF, 1'b0, "cmp_hi_rst");
    add_vec(12'hF03, 2'b01, 32'h1234_5678, 1'b1, 32'h0,        1'b0, "hpm0_wr");
    add_vec(12'hF03, 2'b00, 32'h0,        1'b1, 32'h1234_5678, 1'b0, "hpm0_rd");
    add_vec(12'hF03, 2'b10, 32'h0000_000F, 1'b1, 32'h1234_5678, 1'b0, "hpm0_set");
    add_vec(12'hF03, 2'b00, 32'h0,        1'b1, 32'h1234_567F, 1'b0, "hpm0_rd_set");
    add_vec(12'hF03, 2'b11, 32'h0000_00F0, 1'b1, 32'h1234_567F, 1'b0, "hpm0_clr");
    add_vec(12'hF03, 2'b00, 32'h0,        1'b1, 32'h1234_560F, 1'b0, "hpm0_rd_clr");
    add_vec(12'hF84, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b0, "hpm1_hi_wr");
    add_vec(12'hF84, 2'b00, 32'h0,        1'b1, 32'h0000_00FF, 1'b0, "hpm1_hi_rd");
    add_vec(12'hF04, 2'b00, 32'h0,        1'b1, 32'h0,        1'b0, "hpm1_lo_rd");
    add_vec(12'hF86, 2'b00, 32'h0,        1'b1, 32'h0,        1'b0, "hpm3_hi_rd");
    add_vec(12'hF07, 2'b00, 32'h0,        1'b1, 32'h0,        1'b1, "hpm4_rd_ill");
    add_vec(12'hF87, 2'b00, 32'h0,        1'b1, 32'h0,        1'b1, "hpm4_hi_ill");
    add_vec(12'hF07, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, "hpm4_wr_ill");
    add_vec(12'h123, 2'b00, 32'h0,        1'b1, 32'h0,        1'b1, "unmapped");
    add_vec(12'h320, 2'b00, 32'h0,        1'b1, 32'h0,        1'b0, "inh_rd");
    add_vec(12'h320, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b0, "inh_wr_all");
    add_vec(12'h320, 2'b00, 32'h0,        1'b1, 32'h0000_007F, 1'b0, "inh_rd_mask");
    add_vec(12'h320, 2'b01, 32'h0,        1'b1, 32'h0000_007F, 1'b0, "inh_wr_zero");
    add_vec(12'hC00, 2'b01, 32'h1,        1'b1, 32'h0,        1'b1, "user_wr_ill");
    add_vec(12'hC02, 2'b00, 32'h0,        1'b1, 32'h0,        !USER_EN, "user_rd_instret");
    add_vec(12'hC00, 2'b00, 32'h0,        !USER_EN, 32'h0,    !USER_EN, "user_rd_cycle");
    add_vec(12'hF02, 2'b01, 32'h5,        1'b1, 32'h0,        1'b0, "minstret_wr");
    add_vec(12'hF02, 2'b00, 32'h0,        1'b1, 32'h5,        1'b0, "minstret_rd");

    // Reset state: two reset edges, then a read still under reset.
    rst_i = 1'b1;
    idle(2);
    rd(12'hF00, 32'd0, "rst_mcycle");
    check_irq(1'b0, "rst_irq");
    rst_i = 1'b0;

    // 10 idle cycles after reset.
    idle(10);
    rd(12'hF00, 32'd10, "mcycle_10");
    rd(12'hF02, 32'd0, "minstret_0");
    rd(12'h7C1, 32'hFFFF_FFFF, "mtimecmp_lo_ones");
    check_irq(1'b0, "irq_idle");

    // Low-half carry. The high write drops that cycle's increment, so the
    // low half still reads 13 in the next access.
    wr(12'hF80, 32'd0, 32'd0, "mcycle_hi_wr");
    wr(12'hF00, 32'hFFFF_FFFE, 32'd13, "mcycle_lo_wr_held");
    idle(3);
    rd(12'hF00, 32'd1, "mcycle_carry_lo");
    rd(12'hF80, 32'd1, "mcycle_carry_hi");

    // Table-driven block.
    for (int i = 0; i < tbl.size(); i++)
      access(tbl[i].addr, tbl[i].op, tbl[i].wdata, tbl[i].chk_rd,
             tbl[i].exp_rd, tbl[i].exp_ill, 1'b0, tbl[i].name);

    // Width-40 truncation and wrap-around.
    wr(12'hF80, 32'hFFFF_FFFF, 32'd1, "wrap_hi_wr");
    rd(12'hF80, 32'h0000_00FF, "wrap_hi_trunc");
    access(12'hF00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b0, "wrap_lo_wr");
    rd(12'hF00, 32'hFFFF_FFFF, "wrap_at_max");
    rd(12'hF00, 32'd0, "wrap_lo_zero");
    rd(12'hF80, 32'd0, "wrap_hi_zero");

    // Reset during a write discards it.
    rst_i = 1'b1;
    wr(12'h7C1, 32'd5, 32'hFFFF_FFFF, "rst_mid_write");
    rst_i = 1'b0;

    // Timer: prescaler 4, mtime reaches 3 at the 12th edge after reset.
    wr(12'h7C2, 32'd0, 32'h0000_00FF, "cmp_hi_wr");
    wr(12'h7C1, 32'd3, 32'hFFFF_FFFF, "cmp_lo_wr_discarded");
    idle(9);
    check_irq(1'b0, "irq_before_match");
    idle(1);
    check_irq(1'b1, "irq_at_match");
    wr(12'h7C1, 32'd100, 32'd3, "cmp_raise");
    check_irq(1'b0, "irq_drop");
    rd(12'hF01, 32'd3, "mtime_3");

    // minstret inhibit.
    access(12'h320, 2'b10, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, "inh_set_ir");
    instret_i = 1'b1;
    idle(5);
    instret_i = 1'b0;
    rd(12'hF02, 32'd0, "minstret_inhibited");
    access(12'h320, 2'b11, 32'h4, 1'b1, 32'h4, 1'b0, 1'b0, "inh_clr_ir");
    instret_i = 1'b1;
    idle(2);
    instret_i = 1'b0;
    rd(12'hF02, 32'd2, "minstret_plus2");
    access(12'hF02, 2'b01, 32'd7, 1'b1, 32'd2, 1'b0, 1'b1, "minstret_wr_vs_inc");
    rd(12'hF02, 32'd7, "minstret_write_wins");

    // Event counter and its inhibit bit.
    hpm_event_i = 4'b0100;
    idle(3);
    hpm_event_i = 4'b0000;
    rd(12'hF05, 32'd3, "hpm2_events");
    access(12'h320, 2'b10, 32'h20, 1'b1, 32'h0, 1'b0, 1'b0, "inh_set_hpm2");
    hpm_event_i = 4'b0100;
    idle(2);
    hpm_event_i = 4'b0000;
    rd(12'hF05, 32'd3, "hpm2_inhibited");
    rd(12'hF04, 32'd0, "hpm1_after_rst");

    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kamus_csr_counters.md
Name: kamus_csr_counters

Overview:
- Parametrised machine counter/timer CSR unit for the kamus core.
- Holds mcycle, mtime, minstret, NUM_HPM event counters, mtimecmp and mcountinhibit.
- Serves single-cycle CSR read/modify/write from the execute stage and raises the machine timer interrupt.
- Successor to the fixed 64-bit counter CSR set: configurable width, event-counter count, time prescaler and inhibit control.

Parameters:
- COUNTER_WIDTH, 64, bits per counter (33..64); bits above this read 0, writes to them ignored.
- NUM_HPM, 4, number of event counters (0..29).
- TIME_DIV, 1, clk_i cycles per mtime tick (1..1024).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- csr_valid_i  in  1  CSR access this cycle
- csr_addr_i  in  12  CSR address
- csr_op_i  in  2  00 read, 01 write, 10 set, 11 clear (funct2_system encoding)
- csr_wdata_i  in  32  write / mask operand
- csr_rdata_o  out  32  old value of addressed CSR (combinational)
- csr_illegal_o  out  1  address unmapped, or write to read-only
- instret_i  in  1  one instruction retired this cycle
- hpm_event_i  in  NUM_HPM  per-counter event pulse
- timer_irq_o  out  1  registered, mtime >= mtimecmp

Behaviour:
- Reset (rst_i high at a clock edge): all counters, mtime and the prescaler go to 0. mtimecmp goes to all ones. mcountinhibit goes to 0. timer_irq_o goes to 0. Reset mid-access discards the write.
- Address map:
  - mcycle 0xF00/0xF80, mtime 0xF01/0xF81, minstret 0xF02/0xF82 (low/high halves).
  - hpm[i] at 0xF03+i / 0xF83+i.
  - mtimecmp 0x7C1/0x7C2.
  - mcountinhibit 0x320: bit0 cycle, bit1 time, bit2 instret, bit3+i hpm[i]; unimplemented bits read 0.
- Illegal: any other address, or hpm index >= NUM_HPM. csr_illegal_o is combinational and asserted only while csr_valid_i is high. An illegal access makes no state change and returns rdata 0.
- Write value: op 01 gives wdata; op 10 gives old | wdata; op 11 gives old & ~wdata. It commits at the clock edge ending the access. Op 00 never writes.
- Read returns the pre-write value in the same cycle. The high half returns bits [COUNTER_WIDTH-1:32], zero-extended.
- Increment rules, each evaluated per cycle:
  - mcycle: +1 every cycle.
  - minstret: +1 when instret_i is high.
  - hpm[i]: +1 when hpm_event_i[i] is high.
  - mtime: +1 when the prescaler equals TIME_DIV-1; the prescaler then returns to 0, otherwise it increments.
  - Each counter is held while its mcountinhibit bit is 1. An inhibited mtime also freezes the prescaler.
- Wrap-around: a counter at 2^COUNTER_WIDTH-1 increments to 0, with no flag.
- Simultaneous write and increment on the same counter: the written half takes the write value. The other half holds its old value. The increment is dropped for that cycle. Other counters are unaffected.
- timer_irq_o: registered compare of the next-state mtime >= next-state mtimecmp, so it is valid the cycle after the value changes. It deasserts the cycle after a mtimecmp write that makes the compare false.
- The compare is unsigned over COUNTER_WIDTH.

Optional Feature:
- Macro: KAMUS_USER_COUNTERS_EN.
- Defined: read-only user aliases are mapped.
  - cycle 0xC00/0xC80, time 0xC01/0xC81, instret 0xC02/0xC82.
  - Reads return the same values as the machine CSRs.
  - Any op other than 00 to these addresses asserts csr_illegal_o and makes no change.
- Not defined: 0xC00-0xC02 and 0xC80-0xC82 are illegal.

Test Plan:
- Reset, then 10 idle cycles: read 0xF00 gives 10, 0xF02 gives 0, 0x7C1 gives 0xFFFFFFFF, timer_irq_o is 0.
- Write 0xF80 = 0, then write 0xF00 = 0xFFFFFFFE, wait 3 cycles: read 0xF00 gives 1, read 0xF80 gives 1 (low-half carry).
- COUNTER_WIDTH=40: write 0xF80=0xFFFFFFFF, read gives 0x000000FF. With counter at 2^40-1, next cycle it reads 0.
- TIME_DIV=4: write 0x7C2=0, write 0x7C1=3, 12 cycles later timer_irq_o is 1. Then write 0x7C1=100: timer_irq_o drops the next cycle.
- Set 0x320 bit2 via op 10, pulse instret_i 5 times: minstret unchanged. Clear the bit via op 11, pulse 2 times: minstret +2. In the same cycle as an instret pulse, write 0xF02=7: the next read gives 7.
- Read 0xF03+NUM_HPM gives csr_illegal_o=1 and rdata 0. Write 0xC00: illegal in both macro builds; read 0xC00 is legal only with KAMUS_USER_COUNTERS_EN.
